// File: rtl/opm_pkg.sv
// Shared constants and types for the jt51 (YM2151) write pacing queue.
package opm_pkg;

    localparam logic OPM_A0_ADDR = 1'b0;
    localparam logic OPM_A0_DATA = 1'b1;

    localparam int OPM_DEPTH_DEF    = 16;
    localparam int OPM_STROBE_DEF   = 2;
    localparam int OPM_ADDR_GAP_DEF = 4;
    localparam int OPM_DATA_GAP_DEF = 136;

    typedef enum logic [1:0] {
        OPM_IDLE   = 2'd0,
        OPM_STROBE = 2'd1,
        OPM_GAP    = 2'd2
    } opm_state_e;

    function automatic int opm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/opm_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty and a flush that drops unread entries.
module opm_sync_fifo
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [AW:0]      w_level_nxt;
    logic             r_empty;
    logic             r_full;
    logic             w_push;
    logic             w_pop;

    // full is the registered flag, so a same-cycle pop never makes room for a push
    assign w_push = push && !r_full && !flush;
    assign w_pop  = pop && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (flush)
            w_level_nxt = '0;
        else if (w_push && !w_pop)
            w_level_nxt = r_level + LVL_ONE;
        else if (w_pop && !w_push)
            w_level_nxt = r_level - LVL_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (flush)
                r_rd_ptr <= r_wr_ptr;
            else if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt == LVL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign empty = r_empty;
    assign full  = r_full;

endmodule

// File: rtl/opm_write_queue.sv
// Queues host register writes for the jt51 and replays them with a fixed strobe
// width followed by an address- or data-dependent busy gap.
module opm_write_queue
    import opm_pkg::*;
#(
    parameter int DEPTH         = OPM_DEPTH_DEF,
    parameter int STROBE_CYCLES = OPM_STROBE_DEF,
    parameter int ADDR_GAP      = OPM_ADDR_GAP_DEF,
    parameter int DATA_GAP      = OPM_DATA_GAP_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_stb,
    input  logic                     wr_a0,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic                     ym_cs_n,
    output logic                     ym_wr_n,
    output logic                     ym_a0,
    output logic [7:0]               ym_din,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int GAP_W = $clog2(opm_max(opm_max(ADDR_GAP, DATA_GAP), 1) + 1);
    localparam int STB_W = $clog2(STROBE_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = OPM_IDLE;
    localparam logic [1:0] S_STROBE = OPM_STROBE;
    localparam logic [1:0] S_GAP    = OPM_GAP;

    localparam logic [GAP_W-1:0] GAP_ONE = 1;
    localparam logic [STB_W-1:0] STB_ONE = 1;

    logic [8:0]       w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic [GAP_W-1:0] w_gap_sel;

    logic [1:0]       r_state;
    logic [STB_W-1:0] r_strb_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_cs_n;
    logic             r_a0;
    logic [7:0]       r_din;
    logic             r_ovf;

    opm_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_stb),
        .pop   (w_pop),
        .flush (flush),
        .wdata ({wr_a0, wr_data}),
        .rdata (w_head),
        .level (level),
        .empty (w_empty),
        .full  (w_full)
    );

    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_gap_sel = (r_a0 == OPM_A0_DATA) ? GAP_W'(DATA_GAP) : GAP_W'(ADDR_GAP);

    // One register drives both cs_n and wr_n so they can never skew apart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_strb_cnt <= '0;
            r_gap_cnt  <= '0;
            r_cs_n     <= 1'b1;
            r_a0       <= 1'b0;
            r_din      <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_a0       <= w_head[8];
                        r_din      <= w_head[7:0];
                        r_cs_n     <= 1'b0;
                        r_strb_cnt <= STB_W'(STROBE_CYCLES - 1);
                        r_state    <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (r_strb_cnt == '0) begin
                        r_cs_n <= 1'b1;
                        if (w_gap_sel == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap_cnt <= w_gap_sel;
                            r_state   <= S_GAP;
                        end
                    end else begin
                        r_strb_cnt <= r_strb_cnt - STB_ONE;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_ONE;
                    if (r_gap_cnt == GAP_ONE)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A dropped push wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (wr_stb && w_full && !flush)
            r_ovf <= 1'b1;
        else if (clr_ovf)
            r_ovf <= 1'b0;
    end

    assign ym_cs_n  = r_cs_n;
    assign ym_wr_n  = r_cs_n;
    assign ym_a0    = r_a0;
    assign ym_din   = r_din;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_opm_write_queue.sv
// Bench for opm_write_queue: directed vectors plus random traffic against a timeline model.
module tb_opm_write_queue;

    localparam int DEPTH = 16;
    localparam int SC    = 2;
    localparam int AG    = 4;
    localparam int DG    = 136;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_stb;
    logic       wr_a0;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_ovf;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic       ym_a0;
    logic [7:0] ym_din;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;

    always #5 clk = ~clk;

    opm_write_queue #(
        .DEPTH         (DEPTH),
        .STROBE_CYCLES (SC),
        .ADDR_GAP      (AG),
        .DATA_GAP      (DG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_stb   (wr_stb),
        .wr_a0    (wr_a0),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .ym_cs_n  (ym_cs_n),
        .ym_wr_n  (ym_wr_n),
        .ym_a0    (ym_a0),
        .ym_din   (ym_din),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    int total = 0;
    int bad   = 0;

    // Model: each accepted write gets its strobe start cycle computed from
    // availability (push+2) and the previous start plus strobe plus its gap.
    int         t;
    int         m_level;
    bit         m_ovf;
    int         st_q[$];
    logic [8:0] ent_q[$];

    logic       s_wr;
    logic       s_a0;
    logic [7:0] s_din;
    int         s_lvl;
    int         e_lvl;
    int         pk;
    int         mpk;
    logic       prev_wr;
    int         obs_t[$];
    logic [8:0] obs_e[$];

    typedef struct {
        logic       stb;
        logic       a0;
        logic [7:0] d;
        logic       fl;
        logic       ew;
        logic       ea0;
        logic [7:0] ed;
        int         el;
    } vec_t;
    vec_t tv[14];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, t, act, exp);
        end
    endtask

    function automatic int gapof(input logic a0);
        return a0 ? DG : AG;
    endfunction

    function automatic bit pop_due();
        for (int k = st_q.size() - 1; k >= 0; k--) begin
            if (st_q[k] == t + 1) return 1'b1;
            if (st_q[k] < t + 1) return 1'b0;
        end
        return 1'b0;
    endfunction

    function automatic bit idle_now();
        logic [8:0] le;
        if (st_q.size() == 0) return 1'b1;
        le = ent_q[ent_q.size() - 1];
        return t >= st_q[st_q.size() - 1] + SC + gapof(le[8]);
    endfunction

    task automatic model_check();
        int ew;
        int ea0;
        int ed;
        logic [8:0] le;
        ew = 1; ea0 = 0; ed = 0;
        for (int k = st_q.size() - 1; k >= 0; k--) begin
            if (st_q[k] <= t) begin
                le  = ent_q[k];
                ea0 = int'(le[8]);
                ed  = int'(le[7:0]);
                ew  = (t < st_q[k] + SC) ? 0 : 1;
                break;
            end
        end
        e_lvl = m_level;
        chk("cs_n",     int'(ym_cs_n),  ew);
        chk("wr_n",     int'(ym_wr_n),  ew);
        chk("a0",       int'(ym_a0),    ea0);
        chk("din",      int'(ym_din),   ed);
        chk("level",    int'(level),    m_level);
        chk("empty",    int'(empty),    (m_level == 0) ? 1 : 0);
        chk("full",     int'(full),     (m_level == DEPTH) ? 1 : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic model_update(input logic stb, input logic a0, input logic [7:0] d,
                                input logic fl, input logic clr);
        int pop;
        int nxt;
        int lim;
        logic [8:0] le;
        if (fl) begin
            while (st_q.size() > 0 && st_q[st_q.size() - 1] - 1 > t) begin
                void'(st_q.pop_back());
                void'(ent_q.pop_back());
            end
        end
        pop = pop_due() ? 1 : 0;
        if (stb && !fl && m_level == DEPTH) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (stb && !fl && m_level < DEPTH) begin
            nxt = t + 2;
            if (st_q.size() > 0) begin
                le  = ent_q[ent_q.size() - 1];
                lim = st_q[st_q.size() - 1] + SC + gapof(le[8]) + 1;
                if (lim > nxt) nxt = lim;
            end
            st_q.push_back(nxt);
            ent_q.push_back({a0, d});
            m_level = m_level + 1;
        end
        if (fl) m_level = 0;
        else    m_level = m_level - pop;
        t++;
    endtask

    task automatic cyc(input logic stb, input logic a0, input logic [7:0] d,
                       input logic fl, input logic clr);
        wr_stb = stb; wr_a0 = a0; wr_data = d; flush = fl; clr_ovf = clr;
        @(negedge clk);
        s_wr  = ym_wr_n;
        s_a0  = ym_a0;
        s_din = ym_din;
        s_lvl = int'(level);
        if (prev_wr && !ym_wr_n) begin
            obs_t.push_back(t);
            obs_e.push_back({ym_a0, ym_din});
        end
        prev_wr = ym_wr_n;
        model_check();
        if (s_lvl > pk) pk = s_lvl;
        if (e_lvl > mpk) mpk = e_lvl;
        model_update(stb, a0, d, fl, clr);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (m_level == 0 && idle_now()) done = 1'b1;
            else idle(1);
        end
        chk("wait_idle", int'(done), 1);
    endtask

    task automatic fill_stalled(input logic [7:0] base);
        cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), base + 8'(i), 1'b0, 1'b0);
    endtask

    task automatic hard_reset();
        wr_stb = 1'b0; wr_a0 = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_n",  int'(ym_wr_n),  1);
        chk("rst_cs_n",  int'(ym_cs_n),  1);
        chk("rst_level", int'(level),    0);
        chk("rst_ovf",   int'(overflow), 0);
        chk("rst_empty", int'(empty),    1);
        chk("rst_din",   int'(ym_din),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        st_q.delete(); ent_q.delete();
        m_level = 0; m_ovf = 1'b0; prev_wr = 1'b1;
        t++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bit found;
        rst = 1'b1; wr_stb = 1'b0; wr_a0 = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
        t = 0; m_level = 0; m_ovf = 1'b0; prev_wr = 1'b1; pk = 0; mpk = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("init_wr_n",  int'(ym_wr_n),  1);
        chk("init_cs_n",  int'(ym_cs_n),  1);
        chk("init_a0",    int'(ym_a0),    0);
        chk("init_level", int'(level),    0);
        chk("init_empty", int'(empty),    1);
        chk("init_full",  int'(full),     0);
        chk("init_ovf",   int'(overflow), 0);
        rst = 1'b0;

        // Single address write, then a data write queued behind the 4-cycle address gap
        tv[0]  = '{1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tv[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tv[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 0};
        tv[3]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h08, 0};
        tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1};
        tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1};
        tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1};
        tv[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1};
        tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1};
        tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 0};
        tv[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 0};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 0};
        tv[12] = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h55, 0};
        tv[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(tv[i].stb, tv[i].a0, tv[i].d, tv[i].fl, 1'b0);
            chk($sformatf("t1_wr_%0d", i),  int'(s_wr),  int'(tv[i].ew));
            chk($sformatf("t1_a0_%0d", i),  int'(s_a0),  int'(tv[i].ea0));
            chk($sformatf("t1_din_%0d", i), int'(s_din), int'(tv[i].ed));
            chk($sformatf("t1_lvl_%0d", i), s_lvl,       tv[i].el);
        end

        // Burst of address/data pairs in consecutive cycles
        wait_idle();
        b = obs_t.size(); pk = 0; mpk = 0;
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'(i % 2), (i % 2 == 1) ? 8'hC7 : 8'h20, 1'b0, 1'b0);
        wait_idle();
        chk("t2_peak",   pk, mpk);
        chk("t2_empty",  int'(empty), 1);
        chk("t2_issued", obs_t.size() - b, 16);
        for (int k = 0; k < 16 && b + k < obs_t.size(); k++) begin
            chk("t2_din", int'(obs_e[b + k][7:0]), (k % 2 == 1) ? 8'hC7 : 8'h20);
            if (k > 0 && b + k < obs_t.size())
                chk("t2_spacing", obs_t[b + k] - obs_t[b + k - 1],
                    (k % 2 == 1) ? SC + AG + 1 : SC + DG + 1);
        end

        // Fill while the FSM sits in a long data gap; 17th push overflows
        wait_idle();
        b = obs_t.size();
        fill_stalled(8'h10);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_full",  int'(full),     1);
        chk("t3_level", s_lvl,          DEPTH);
        chk("t3_ovf",   int'(overflow), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_ovf_clr", int'(overflow), 0);
        wait_idle();
        chk("t3_issued", obs_t.size() - b, DEPTH + 1);

        // Push, pop and clr_ovf together while full
        fill_stalled(8'h80);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (pop_due()) found = 1'b1;
            else idle(1);
        end
        chk("t6_pop_window", int'(found), 1);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_level", s_lvl,          DEPTH - 1);
        chk("t6_ovf",   int'(overflow), 1);
        chk("t6_full",  int'(full),     0);

        // Reset in the middle of a strobe
        chk("t5_pre_wr", int'(s_wr), 0);
        hard_reset();
        cyc(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        chk("t5_lat0", int'(s_wr), 1);
        idle(1);
        chk("t5_lat1", int'(s_wr), 1);
        idle(1);
        chk("t5_lat2", int'(s_wr), 0);
        chk("t5_din",  int'(s_din), 8'h33);
        idle(1);
        chk("t5_lat3", int'(s_wr), 0);
        idle(1);
        chk("t5_lat4", int'(s_wr), 1);

        // Flush during a strobe with five entries still queued
        wait_idle();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_level_pre", s_lvl,      5);
        chk("t4_wr_pre",    int'(s_wr), 0);
        idle(1);
        chk("t4_level_post", s_lvl,      0);
        chk("t4_wr_hold",    int'(s_wr), 0);
        idle(1);
        chk("t4_wr_end", int'(s_wr), 1);
        b = obs_t.size();
        idle(200);
        chk("t4_no_strobe", obs_t.size() - b, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 49) == 0));
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
